// File: rtl/rgb_pkg.sv
// Shared LED definitions for the rainbow designs: active-low colour codes,
// LED bit positions and the default PWM resolution.
package rgb_pkg;

   localparam int PWM_BITS_DEF = 8;

   // Bit positions inside the active-low led[2:0] bus
   localparam int LED_R = 2;
   localparam int LED_B = 1;
   localparam int LED_G = 0;

   // Active-low colour encodings: a 0 bit lights that channel
   typedef enum logic [2:0] {
      WHITE   = 3'b000,
      MAGENTA = 3'b001,
      YELLOW  = 3'b010,
      RED     = 3'b011,
      CYAN    = 3'b100,
      BLUE    = 3'b101,
      GREEN   = 3'b110,
      OFF     = 3'b111
   } led_colour_t;

   // Maps per-channel on flags onto the active-low LED bus
   function automatic logic [2:0] led_drive(input logic r_on,
                                            input logic g_on,
                                            input logic b_on);
      logic [2:0] v;
      v        = 3'b111;
      v[LED_R] = ~r_on;
      v[LED_G] = ~g_on;
      v[LED_B] = ~b_on;
      return v;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clock prescaler feeding a frame step counter. Produces the
// step count within the frame, the last-step boundary strobe and a pulse in
// the first clock of every frame.
module pwm_timebase
   import rgb_pkg::*;
#(
   parameter int PWM_BITS = PWM_BITS_DEF,
   parameter int PRESCALE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [PWM_BITS-1:0] pwm_cnt,
   output logic                boundary,
   output logic                frame_start
);

   // A single-tick prescaler still needs a 1-bit register to stay legal
   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CNT_W = $clog2(1 << PWM_BITS);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << PWM_BITS) - 2);

   logic [PRE_W-1:0] pre_cnt;
   logic [CNT_W-1:0] step_cnt;
   logic             step;

   // Step strobe, frame-end boundary and frame-start pulse
   always_comb begin
      step        = (pre_cnt == PRE_LAST);
      boundary    = step && (step_cnt == CNT_LAST);
      frame_start = (step_cnt == '0) && (pre_cnt == '0);
   end

   // Prescaler: counts clk ticks within one PWM step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pre_cnt <= '0;
      else if (step)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + PRE_W'(1);
   end

   // Frame counter: 0 .. 2^PWM_BITS-2, so a full-scale duty is never crossed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         step_cnt <= '0;
      else if (boundary)
         step_cnt <= '0;
      else if (step)
         step_cnt <= step_cnt + CNT_W'(1);
   end

   assign pwm_cnt = PWM_BITS'(step_cnt);

endmodule

// File: rtl/rgb_pwm_driver.sv
// Tri-colour LED PWM driver. A colour word is accepted into a pending buffer
// over valid/ready and copied to the active buffer only at a frame boundary,
// so every frame is rendered with one consistent set of duties.
module rgb_pwm_driver
   import rgb_pkg::*;
#(
   parameter int PWM_BITS = PWM_BITS_DEF,
   parameter int PRESCALE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [PWM_BITS-1:0] in_r,
   input  logic [PWM_BITS-1:0] in_g,
   input  logic [PWM_BITS-1:0] in_b,
   output logic                frame_start,
   output logic [2:0]          led
);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic                boundary;

   logic [PWM_BITS-1:0] pend_r, pend_g, pend_b;
   logic                pend_full;
   logic [PWM_BITS-1:0] act_r, act_g, act_b;

   logic accept;
   logic apply;
   logic r_on, g_on, b_on;

   pwm_timebase #(
      .PWM_BITS (PWM_BITS),
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk         (clk),
      .rst_n       (rst_n),
      .pwm_cnt     (pwm_cnt),
      .boundary    (boundary),
      .frame_start (frame_start)
   );

   // Handshake and buffer transfer strobes; accept and apply never coincide
   // because accept needs an empty pending buffer and apply needs a full one
   always_comb begin
      in_ready = ~pend_full;
      accept   = in_valid && ~pend_full;
      apply    = boundary && pend_full;
   end

   // Pending colour data: captured on accept, no reset needed for data
   always_ff @(posedge clk) begin
      if (accept) begin
         pend_r <= in_r;
         pend_g <= in_g;
         pend_b <= in_b;
      end
   end

   // Pending flag: set on accept, cleared when the word moves to active
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pend_full <= 1'b0;
      else if (accept)
         pend_full <= 1'b1;
      else if (apply)
         pend_full <= 1'b0;
   end

   // Active colour: only changes at a frame boundary with a word waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_r <= '0;
         act_g <= '0;
         act_b <= '0;
      end else if (apply) begin
         act_r <= pend_r;
         act_g <= pend_g;
         act_b <= pend_b;
      end
   end

   // Per-channel comparators against the frame step count
   always_comb begin
      r_on = (pwm_cnt < act_r);
      g_on = (pwm_cnt < act_g);
      b_on = (pwm_cnt < act_b);
   end

   // Registered LED drive; reset forces all channels dark immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         led <= OFF;
      else
         led <= led_drive(r_on, g_on, b_on);
   end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Testbench for rgb_pwm_driver: cycle-by-cycle comparison against a
// frame-arithmetic reference model, table of duty vectors measured over a
// full frame, and hand sequences for boundary accept, back-to-back words and
// asynchronous reset.
module tb_rgb_pwm_driver;
   import rgb_pkg::*;

   localparam int PWM_BITS = 8;
   localparam int PRESCALE = 4;
   localparam int STEPS    = (1 << PWM_BITS) - 1;
   localparam int F        = PRESCALE * STEPS;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_r = '0, in_g = '0, in_b = '0;
   logic       in_ready;
   logic       frame_start;
   logic [2:0] led;

   rgb_pwm_driver #(.PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_r        (in_r),
      .in_g        (in_g),
      .in_b        (in_b),
      .frame_start (frame_start),
      .led         (led)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int t = 0;

   // Model history: accept cycle, apply cycle and duties of every word
   int q_ta[$];
   int q_ap[$];
   int q_r[$];
   int q_g[$];
   int q_b[$];

   bit count_en = 0;
   int low_cnt[3];

   typedef struct {
      logic [7:0] r, g, b;
      int lo_r, lo_g, lo_b;
   } vec_t;
   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
      end
   endtask

   // First frame-end cycle strictly after the accept cycle
   function automatic int apply_at(input int ta);
      int b;
      b = (ta / F) * F + F - 1;
      if (b == ta) b += F;
      return b;
   endfunction

   // Ready is low while any accepted word is waiting for its boundary
   function automatic bit exp_ready(input int tt);
      foreach (q_ta[i])
         if (q_ta[i] < tt && tt <= q_ap[i]) return 1'b0;
      return 1'b1;
   endfunction

   // LED in cycle tt shows the comparison made in cycle tt-1
   function automatic logic [2:0] exp_led(input int tt);
      int s, p, r, g, b;
      s = tt - 1;
      r = 0; g = 0; b = 0;
      if (s < 0) return 3'b111;
      foreach (q_ap[i])
         if (q_ap[i] < s) begin
            r = q_r[i]; g = q_g[i]; b = q_b[i];
         end
      p = (s % F) / PRESCALE;
      return {!(p < r), !(p < b), !(p < g)};
   endfunction

   // One clock: called at posedge+1, checks at negedge, returns at next posedge+1
   task automatic cycle();
      @(negedge clk);
      check("in_ready", 32'(in_ready), 32'(exp_ready(t)));
      check("led", 32'(led), 32'(exp_led(t)));
      check("frame_start", 32'(frame_start), 32'((t % F) == 0));
      if (count_en)
         for (int k = 0; k < 3; k++)
            if (!led[k]) low_cnt[k]++;
      if (in_valid && exp_ready(t)) begin
         q_ta.push_back(t);
         q_ap.push_back(apply_at(t));
         q_r.push_back(int'(in_r));
         q_g.push_back(int'(in_g));
         q_b.push_back(int'(in_b));
      end
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic run_to(input int tt);
      while (t < tt) cycle();
   endtask

   task automatic do_reset(input int hold);
      rst_n = 1'b0;
      repeat (hold) begin
         @(negedge clk);
         check("rst_led", 32'(led), 32'(3'b111));
         check("rst_ready", 32'(in_ready), 32'd1);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      t = 0;
      q_ta.delete(); q_ap.delete(); q_r.delete(); q_g.delete(); q_b.delete();
   endtask

   task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      int n, guard;
      in_valid = 1'b1; in_r = r; in_g = g; in_b = b;
      n = q_ta.size();
      guard = 0;
      while (q_ta.size() == n && guard < 3 * F) begin
         cycle();
         guard++;
      end
      if (q_ta.size() == n) begin
         failures++;
         $display("FAIL send_timeout t=%0d actual=no_accept required=accept", t);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      tbl[0] = '{8'd255, 8'd0,   8'd0,   1020, 0,    0};
      tbl[1] = '{8'd64,  8'd128, 8'd0,   256,  512,  0};
      tbl[2] = '{8'd0,   8'd0,   8'd0,   0,    0,    0};
      tbl[3] = '{8'd1,   8'd254, 8'd100, 4,    1016, 400};
      tbl[4] = '{8'd255, 8'd255, 8'd255, 1020, 1020, 1020};

      @(posedge clk);
      #1;

      // Reset held with in_valid high; word presented is accepted at release
      in_valid = 1'b1; in_r = 8'd255; in_g = 8'd0; in_b = 8'd0;
      do_reset(5);
      cycle();
      in_valid = 1'b0;
      run_to(1040);

      // Table vectors: count low clocks of each LED bit over one full frame
      foreach (tbl[i]) begin
         do_reset(2);
         send(tbl[i].r, tbl[i].g, tbl[i].b);
         run_to(F + 1);
         for (int k = 0; k < 3; k++) low_cnt[k] = 0;
         count_en = 1;
         run_to(2 * F + 1);
         count_en = 0;
         check("lo_red",   32'(low_cnt[LED_R]), 32'(tbl[i].lo_r));
         check("lo_green", 32'(low_cnt[LED_G]), 32'(tbl[i].lo_g));
         check("lo_blue",  32'(low_cnt[LED_B]), 32'(tbl[i].lo_b));
      end

      // Accept in the exact boundary cycle: applied one frame later
      do_reset(1);
      send(8'd200, 8'd10, 8'd50);
      run_to(2 * F - 1);
      #3;
      check("bnd_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_r = 8'd10; in_g = 8'd200; in_b = 8'd50;
      cycle();
      in_valid = 1'b0;
      run_to(2 * F + 401);
      #3;
      check("bnd_old_colour", 32'(led), 32'(3'b011));
      run_to(3 * F + 401);
      #3;
      check("bnd_new_colour", 32'(led), 32'(3'b110));
      run_to(3 * F + 420);

      // Back-to-back words with in_valid held high
      do_reset(1);
      begin
         logic [7:0] wr[3], wg[3], wb[3];
         int idx, n;
         wr = '{8'd30, 8'd220, 8'd0};
         wg = '{8'd90, 8'd5,   8'd255};
         wb = '{8'd150, 8'd77, 8'd128};
         idx = 0;
         in_valid = 1'b1; in_r = wr[0]; in_g = wg[0]; in_b = wb[0];
         while (t < 4 * F + 20) begin
            n = q_ta.size();
            cycle();
            if (q_ta.size() > n) begin
               idx++;
               if (idx < 3) begin
                  in_r = wr[idx]; in_g = wg[idx]; in_b = wb[idx];
               end else begin
                  in_valid = 1'b0;
               end
            end
         end
         in_valid = 1'b0;
      end

      // Asynchronous reset mid-frame with an in-flight word
      do_reset(1);
      send(8'd255, 8'd255, 8'd255);
      run_to(F + 480);
      in_valid = 1'b1; in_r = 8'd9; in_g = 8'd99; in_b = 8'd199;
      cycle();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_led", 32'(led), 32'(3'b111));
      check("async_ready", 32'(in_ready), 32'd1);
      do_reset(2);
      run_to(F + 30);

      // Randomized traffic, biased toward extreme duties and boundary accepts
      do_reset(1);
      while (t < 7000) begin
         int n;
         if (!in_valid) begin
            if (((t % F) == F - 1) ? ($urandom_range(1) == 1) : ($urandom_range(199) == 0)) begin
               in_valid = 1'b1;
               case ($urandom_range(3))
                  0: in_r = 8'd0;
                  1: in_r = 8'd255;
                  default: in_r = 8'($urandom);
               endcase
               in_g = 8'($urandom);
               in_b = ($urandom_range(1) == 1) ? 8'd255 : 8'($urandom);
            end
         end
         n = q_ta.size();
         cycle();
         if (q_ta.size() > n) in_valid = 1'b0;
      end
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Downstream LED stage for the rainbow designs: accepts a target colour as three per-channel duty values over a valid/ready handshake and drives the on-board tri-colour LED with frame-aligned PWM. This gives true intensity blending instead of toggling between base colours. It replaces direct `led` register writes in colour generators, sitting between any colour source and the `led[2:0]` pins. Updates are double-buffered and take effect only at PWM frame boundaries, so no frame is ever rendered with mixed old/new duties.

## Interface
- `PWM_BITS`, 8: duty width; frame length is 2^PWM_BITS-1 steps.
- `PRESCALE`, 4: clk ticks per PWM step (>=1).
- `clk`  in  1  system clock (24 MHz on board).
- `rst_n`  in  1  reset, asynchronous, active-low; top level ties `button_a` directly.
- `in_valid`  in  1  colour word valid.
- `in_ready`  out  1  pending buffer empty; transfer on `in_valid && in_ready`.
- `in_r`, `in_g`, `in_b`  in  PWM_BITS each  duty per channel, 0 = off, 2^PWM_BITS-1 = fully on.
- `frame_start`  out  1  one-cycle pulse in the first cycle of every PWM frame.
- `led`  out  3  active-low LED drive: bit2 = red, bit1 = blue, bit0 = green (RED = 3'b011, GREEN = 3'b110, BLUE = 3'b101, OFF = 3'b111).

## Operation
- Timebase:
  - `pre_cnt` counts 0..PRESCALE-1 and wraps.
  - `step` = (`pre_cnt` == PRESCALE-1).
  - `pwm_cnt` counts 0..2^PWM_BITS-2 and advances on `step`.
  - `boundary` = `step` && `pwm_cnt` == 2^PWM_BITS-2; `pwm_cnt` wraps to 0 on `boundary`.
- Buffers:
  - `pend_{r,g,b}` plus `pend_full` hold the next colour.
  - `act_{r,g,b}` hold the colour currently rendered.
  - `in_ready` = !`pend_full` (combinational from the flag).
- Accept: on `in_valid && in_ready`, the inputs are captured into `pend_*` and `pend_full` is set.
- Apply: on `boundary` with `pend_full`=1, `act_*` <= `pend_*` and `pend_full` is cleared. `in_ready` reads 1 from the next cycle.
- Simultaneous accept and `boundary` (pend empty): the word goes to `pend_*` and is applied at the following boundary, not the current one.
- Boundary with `pend_full`=0: `act_*` is unchanged, and the previous colour repeats indefinitely.
- Compare: channel on = (`pwm_cnt` < `act_x`). `led` <= ~{r_on, b_on, g_on}, registered.
- Duty 0 keeps the channel dark for the whole frame. Duty 2^PWM_BITS-1 keeps it lit for the whole frame, with no glitch at wrap.
- `frame_start` = (`pwm_cnt`==0 && `pre_cnt`==0). It fires in the first cycle after reset release and every frame thereafter.
- Reset, asynchronous, at any time:
  - `led`=3'b111 immediately.
  - `pre_cnt`, `pwm_cnt`, and `act_*` = 0.
  - `pend_full`=0, so `in_ready`=1 while in reset.
  - Any in-flight word is discarded.
- Width rules: counters are sized with $clog2. All compares are unsigned at PWM_BITS width, with no overflow paths.

## Timing
- Frame = PRESCALE*(2^PWM_BITS-1) clocks. The default is 1020 clocks (≈23.5 kHz).
- Per channel with duty d: `led` bit is low for exactly d*PRESCALE consecutive clocks per frame, starting 1 clock after `frame_start` (output register latency).
- Handshake-to-light latency: from the accept cycle to the next boundary, plus 2 clocks. Worst case is 1 frame + 2 clocks.
- `in_ready` is low from the cycle after accept until the cycle after the applying boundary. At most one word is outstanding.

## Structure
- Shared package `rgb_pkg`:
  - colour encodings WHITE, MAGENTA, YELLOW, RED, CYAN, BLUE, GREEN, OFF;
  - LED bit indices LED_R=2, LED_B=1, LED_G=0;
  - default PWM_BITS.
- One sub-module, `pwm_timebase`: prescaler plus frame counter. It exports `pwm_cnt`, `boundary` and `frame_start`.
- The top level holds the buffers, handshake and comparators.

## Test plan
- Reset held, `in_valid`=1 -> `led`=3'b111 and `in_ready`=1 throughout. After release, the first `frame_start` arrives on the first clock.
- Send (255,0,0) with PRESCALE=4 -> from the next frame, `led`=3'b011 constantly. `in_ready` is low until the cycle after the boundary.
- Send (64,128,0) -> per 1020-clock frame, bit2 is low for 256 clocks and bit0 for 512 clocks; bit1 stays high.
- Accept in the exact boundary cycle -> the current frame keeps the old duties and the new ones start one frame later.
- Hold `in_valid`=1 with two words back-to-back -> the second is stalled until the first applies, and each is rendered for at least one full frame with none lost.
- Assert `rst_n`=0 mid-frame with duty (255,255,255) -> `led` goes to 3'b111 in the same cycle, without waiting for a clock edge.
